// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot loader that turns a byte stream into instruction-memory
//               writes and holds the core in reset until the image is complete.
//               Optional trailing checksum byte: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int WORDS  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [31:0]     r_len;
    logic [31:0]     r_word;
    logic [1:0]      r_byte_cnt;
    logic [ADDR_W:0] r_words_loaded;
    logic [ADDR_W:0] w_wl_inc;
    logic [31:0]     w_len_full;
    logic            w_accept;
    logic            w_last_byte;
    logic            w_load_start;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    assign rx_ready     = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CHK);
    assign w_accept     = rx_valid && rx_ready;
    assign w_last_byte  = (r_byte_cnt == 2'd3);
    // Header decision is made on the edge that accepts byte 3, before r_len holds it.
    assign w_len_full   = {rx_data, r_len[23:0]};
    assign w_wl_inc     = r_words_loaded + 1'b1;
    assign busy         = rx_ready || (r_state == ST_WRITE);
    assign done         = (r_state == ST_DONE);
    assign error        = (r_state == ST_ERR);
    assign cpu_rst_n    = (r_state == ST_DONE);
    assign words_loaded = r_words_loaded;

    always_comb begin
        w_next       = r_state;
        w_load_start = 1'b0;
        im_we        = 1'b0;
        im_addr      = '0;
        im_wdata     = '0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_next       = ST_HDR;
                    w_load_start = 1'b1;
                end
            end
            ST_HDR: begin
                if (w_accept && w_last_byte) begin
                    if ((w_len_full == 32'd0) || (w_len_full > 32'(WORDS)))
                        w_next = ST_ERR;
                    else
                        w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_accept && w_last_byte)
                    w_next = ST_WRITE;
            end
            ST_WRITE: begin
                im_we    = 1'b1;
                im_addr  = r_words_loaded[ADDR_W-1:0];
                im_wdata = r_word;
                if (32'(w_wl_inc) == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next = ST_CHK;
`else
                    w_next = ST_DONE;
`endif
                end else begin
                    w_next = ST_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (w_accept)
                    w_next = (rx_data == r_csum) ? ST_DONE : ST_ERR;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_len          <= '0;
            r_word         <= '0;
            r_byte_cnt     <= '0;
            r_words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum         <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (w_load_start) begin
                r_byte_cnt     <= '0;
                r_words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_csum         <= '0;
`endif
            end
            if (w_accept && (r_state == ST_HDR)) begin
                r_len[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
                r_byte_cnt                       <= r_byte_cnt + 2'd1;
            end
            if (w_accept && (r_state == ST_DATA)) begin
                r_word[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
                r_byte_cnt                        <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_csum                            <= r_csum ^ rx_data;
`endif
            end
            if (im_we)
                r_words_loaded <= w_wl_inc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// Testbench for imem_loader: randomized byte streams against a stream-level model
// of the expected instruction-memory writes and final load status.
module tb_imem_loader;
    localparam int WORDS  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [ADDR_W:0] addr;
        logic [31:0]     data;
    } wr_t;
    typedef wr_t wq_t[$];

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    wq_t exp_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every write must match the head of the expected-write list, in order.
    always @(negedge clk) begin
        wr_t w;
        if (mon_en) begin
            check("cpu_rst_n_vs_done", 64'(cpu_rst_n), 64'(done));
            check("status_exclusive", 64'(int'(busy) + int'(done) + int'(error) <= 1), 64'd1);
            if (im_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("im_addr", 64'(im_addr), 64'(w.addr[ADDR_W-1:0]));
                    check("im_wdata", 64'(im_wdata), 64'(w.data));
                    check("words_loaded_at_write", 64'(words_loaded), 64'(w.addr));
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        check({tag, "_im_we"}, 64'(im_we), 64'd0);
        check({tag, "_im_addr"}, 64'(im_addr), 64'd0);
        check({tag, "_im_wdata"}, 64'(im_wdata), 64'd0);
        check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    // Presents bytes with random idle gaps; a presented byte is held until taken.
    // Returns just after the edge that accepts the final byte (rx_valid still high).
    task automatic send(input bq_t s, input int gap_pct);
        int  idx = 0;
        int  cyc = 0;
        int  budget;
        bit  acc = 1'b0;
        budget = 10 * s.size() + 100;
        while (idx < s.size() && cyc < budget) begin
            @(negedge clk);
            if (acc) rx_valid = 1'b0;
            if (!rx_valid && ($urandom_range(99) >= gap_pct)) begin
                rx_valid = 1'b1;
                rx_data  = s[idx];
            end
            acc = rx_valid && rx_ready;
            cyc++;
            @(posedge clk);
            if (acc) idx++;
        end
        if (idx < s.size()) check("send_timeout", 64'(idx), 64'(s.size()));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Stream-level model: header, payload words, optional XOR checksum byte.
    task automatic build(input logic [31:0] len, output bq_t s, output wq_t w, output bit ok);
        logic [31:0] word;
        logic [7:0]  x;
        wr_t         e;
        x = 8'h00;
        s = {};
        w = {};
        for (int i = 0; i < 4; i++) s.push_back(len[8*i +: 8]);
        ok = (len != 32'd0) && (len <= 32'(WORDS));
        if (ok) begin
            for (int i = 0; i < int'(len); i++) begin
                word = $urandom;
                for (int k = 0; k < 4; k++) begin
                    s.push_back(word[8*k +: 8]);
                    x = x ^ word[8*k +: 8];
                end
                e.addr = (ADDR_W+1)'(i);
                e.data = word;
                w.push_back(e);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            s.push_back(x);
`endif
        end
    endtask

    task automatic run_load(input bq_t s, input wq_t w, input bit ok, input int gap_pct);
        int nw;
        nw    = w.size();
        exp_q = w;
        pulse_start();
        check("busy_after_start", 64'(busy), 64'd1);
        check("rx_ready_after_start", 64'(rx_ready), 64'd1);
        check("words_loaded_cleared", 64'(words_loaded), 64'd0);
        send(s, gap_pct);
        @(negedge clk);
        rx_valid = 1'b0;
        if (!ok) begin
            check("error_flag", 64'(error), 64'd1);
            check("error_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        end else begin
`ifndef IMEM_LOADER_CHECKSUM_EN
            check("last_write_strobe", 64'(im_we), 64'd1);
            @(negedge clk);
`endif
            check("done_flag", 64'(done), 64'd1);
            check("done_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
            check("final_words_loaded", 64'(words_loaded), 64'(nw));
        end
        check("writes_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t   s;
        bq_t   part;
        wq_t   w;
        wq_t   none;
        wr_t   e;
        bit    ok;
        logic [31:0] len;
        int    r;

        none = {};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Two-word load with hand-computed words.
        s = {8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'hB0);
`endif
        w = {};
        e.addr = '0; e.data = 32'h00100513; w.push_back(e);
        e.addr = (ADDR_W+1)'(1); e.data = 32'h00200593; w.push_back(e);
        run_load(s, w, 1'b1, 0);
        run_load(s, w, 1'b1, 60);

        // Start while in DONE drops the core reset on the next edge.
        pulse_start();
        check("restart_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_words_loaded", 64'(words_loaded), 64'd0);

        // Bad lengths: zero and 257.
        run_load({8'h00, 8'h00, 8'h00, 8'h00}, none, 1'b0, 0);
        run_load({8'h01, 8'h01, 8'h00, 8'h00}, none, 1'b0, 30);

`ifdef IMEM_LOADER_CHECKSUM_EN
        s[s.size()-1] = 8'h06;
        run_load(s, w, 1'b0, 10);
        s[s.size()-1] = 8'hB0;
`endif

        // Reset after the sixth byte: no writes afterwards, back to IDLE.
        exp_q = {};
        pulse_start();
        part = s[0:5];
        send(part, 30);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("midload_reset");
        rst_n    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            check("idle_rx_ready", 64'(rx_ready), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end
        rx_valid = 1'b0;
        run_load(s, w, 1'b1, 20);

        // Randomized loads, including invalid lengths.
        for (int it = 0; it < 12; it++) begin
            r = $urandom_range(9);
            if (r == 0)      len = 32'd0;
            else if (r == 1) len = 32'($urandom_range(257, 70000));
            else             len = 32'($urandom_range(1, 6));
            build(len, s, w, ok);
            run_load(s, w, ok, $urandom_range(0, 60));
        end

        // Full-depth image.
        build(32'(WORDS), s, w, ok);
        run_load(s, w, ok, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
